// File: rtl/serial_add_sub_pkg.sv
// ============================================================================
//  serial_add_sub_pkg : shared FSM encoding for the bit-serial arithmetic units
//  Revision: 1.0
// ============================================================================
`default_nettype none

package serial_add_sub_pkg;

  // Encoding is fixed so the serial multiplier/divider can reuse it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_add_sub_full_adder_cell.sv
// ============================================================================
//  half_adder / full_adder_cell : combinational one-bit adder built from two
//  half adders and an OR.  Revision: 1.0
// ============================================================================
`default_nettype none

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (.a(a),    .b(b),   .sum(w_s1), .cout(w_c1));
  half_adder u_ha1 (.a(w_s1), .b(cin), .sum(sum),  .cout(w_c2));

  assign cout = w_c1 | w_c2;
endmodule

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
//  serial_add_sub : bit-serial WIDTH-bit adder/subtractor, one full adder
//  reused over WIDTH cycles with a registered carry.  Revision: 1.0
// ============================================================================
`default_nettype none

module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int                c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic w_fa_sum;
  logic w_fa_cout;
  logic w_load;

  full_adder_cell u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    w_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          w_load  = 1'b1;
        end
      end
      ST_SHIFT: begin
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        res_d   = {w_fa_sum, res_q[WIDTH-1:1]};
        carry_d = w_fa_cout;
        count_d = count_q + c_CNT_W'(1);
        if (count_q == c_LAST) begin
          state_d = ST_DONE;
          cout_d  = w_fa_cout;
          // carry_q is the carry into the MSB at this point
          ovf_d   = carry_q ^ w_fa_cout;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_SHIFT;
          w_load  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Subtract is a + ~b + 1: invert b and seed the carry with 1.
    if (w_load) begin
      sa_d    = a;
      sb_d    = sub ? ~b : b;
      carry_d = sub;
      count_d = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
// ============================================================================
//  tb_serial_add_sub : directed and random self-checking bench for
//  serial_add_sub at WIDTH=8.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       overflow;

  int errors;
  int checks;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, cout, result} from a 9-bit two's complement sum.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic ms);
    logic [8:0] s;
    logic [7:0] bb;
    logic       v;
    bb = ms ? ~mb : mb;
    s  = {1'b0, ma} + {1'b0, bb} + {8'd0, ms};
    if (ms) v = (ma[7] != mb[7]) && (s[7] != ma[7]);
    else    v = (ma[7] == mb[7]) && (s[7] != ma[7]);
    return {v, s[8], s[7:0]};
  endfunction

  // Launches one operation and waits (bounded) for done; returns edges and busy cycles seen.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic os,
                        output int n_edges, output int n_busy);
    a = oa; b = ob; sub = os; start = 1'b1;
    n_edges = 0;
    n_busy  = 0;
    do begin
      tick();
      n_edges++;
      if (n_edges == 1) start = 1'b0;
      if (busy) n_busy++;
    end while (!done && n_edges < 30);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    checks++;
    if ({busy, done, result, cout, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h cout=%b ovf=%b, required all 0",
               busy, done, result, cout, overflow);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_vec(input string name, input logic [7:0] va, input logic [7:0] vb,
                          input logic vs, input logic [7:0] er, input logic ec, input logic ev);
    int n, nb;
    run_op(va, vb, vs, n, nb);
    checks++;
    if (n !== 9 || !done) begin
      errors++;
      $display("FAIL %s latency: edges=%0d done=%b, required 9 1", name, n, done);
    end
    checks++;
    if (nb !== 8) begin
      errors++;
      $display("FAIL %s busy_width: %0d, required 8", name, nb);
    end
    checks++;
    if (result !== er || cout !== ec || overflow !== ev) begin
      errors++;
      $display("FAIL %s value: result=%h cout=%b ovf=%b, required %h %b %b",
               name, result, cout, overflow, er, ec, ev);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done);
    end
  endtask

  task automatic test_add();
    test_vec("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    test_vec("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    test_vec("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    test_vec("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
    test_vec("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0);
    test_vec("sub_37_37", 8'h37, 8'h37, 1'b1, 8'h00, 1'b1, 1'b0);
    test_vec("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    int ndone, nbusy;
    a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    // fourth busy cycle: reset together with a start request
    rst = 1'b1; start = 1'b1;
    tick();
    checks++;
    if ({busy, done, result, cout, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b result=%h cout=%b ovf=%b, required all 0",
               busy, done, result, cout, overflow);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_over_start: busy=%b, required 0", busy);
    end
    rst = 1'b0; start = 1'b0;
    ndone = 0; nbusy = 0;
    repeat (15) begin
      tick();
      if (done) ndone++;
      if (busy) nbusy++;
    end
    checks++;
    if (ndone !== 0 || nbusy !== 0) begin
      errors++;
      $display("FAIL discarded_op: done=%0d busy=%0d cycles, required 0 0", ndone, nbusy);
    end
    test_vec("fresh_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    int n, ndone, first_done;
    logic [7:0] r_at_done;
    a = 8'h05; b = 8'h03; sub = 1'b0; start = 1'b1;
    n = 0; ndone = 0; first_done = 0; r_at_done = '0;
    repeat (20) begin
      tick();
      n++;
      start = 1'b0;
      if (n == 3) begin
        a = 8'h11; b = 8'h22; start = 1'b1;
      end
      if (done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = n;
          r_at_done  = result;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || first_done !== 9) begin
      errors++;
      $display("FAIL ignore_start done: count=%0d at_edge=%0d, required 1 9", ndone, first_done);
    end
    checks++;
    if (r_at_done !== 8'h08) begin
      errors++;
      $display("FAIL ignore_start result: %h, required 08", r_at_done);
    end
  endtask

  task automatic test_back_to_back();
    int n, nb;
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      a = 8'h0A; b = 8'h0B;
    end while (!done && n < 30);
    checks++;
    if (n !== 9 || result !== 8'h03) begin
      errors++;
      $display("FAIL b2b first: edges=%0d result=%h, required 9 03", n, result);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b no_gap: busy=%b done=%b, required 1 0", busy, done);
    end
    n = 1; nb = 1;
    while (!done && n < 30) begin
      tick();
      n++;
      if (busy) nb++;
    end
    checks++;
    if (n !== 9 || nb !== 8) begin
      errors++;
      $display("FAIL b2b second timing: edges=%0d busy=%0d, required 9 8", n, nb);
    end
    checks++;
    if (result !== 8'h15 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b second value: result=%h cout=%b ovf=%b, required 15 0 0",
               result, cout, overflow);
    end
    tick();
  endtask

  task automatic test_random();
    int n, nb;
    logic [7:0] ra, rb;
    logic       rs;
    logic [9:0] exp;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (i % 50 == 0) begin
        rb = ra;
        rs = 1'b1;
      end
      exp = model(ra, rb, rs);
      run_op(ra, rb, rs, n, nb);
      checks++;
      if (n !== 9 || nb !== 8) begin
        errors++;
        $display("FAIL rand%0d timing: edges=%0d busy=%0d, required 9 8", i, n, nb);
      end
      checks++;
      if ({overflow, cout, result} !== exp) begin
        errors++;
        $display("FAIL rand%0d %h %s %h: ovf/cout/result=%b/%b/%h, required %b/%b/%h",
                 i, ra, rs ? "-" : "+", rb, overflow, cout, result, exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_sub();
    test_mid_reset();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
